memoria_param: RTL and testbench

MEMORIA_PARAM -- requirements
Module: memoria_param

---
 rtl/memoria_param.sv | 142 ++++++++++++++
 tb/tb_memoria_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memoria_param.sv
`default_nettype none
// ============================================================================
// memoria_param : parameterised single-clock RAM with self-clearing sweep,
//                 1- or 2-cycle pipelined reads and selectable collision mode.
// Revision 1.0
// ============================================================================
module memoria_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int LATENCIA     = 1,
  parameter int MODO_COLISAO = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  EscMen,
  input  logic                  LerMen,
  input  logic                  limpar,
  output logic [DATA_WIDTH-1:0] saida,
  output logic                  saida_valida,
  output logic                  ocupada
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    LIMPA  = 1'b0,
    PRONTA = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   saida_q;
  logic                    valida_q;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic                    w_flush;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LIMPA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // limpar wins over any access requested in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    w_flush = 1'b0;
    case (state_q)
      LIMPA: begin
        w_flush = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = PRONTA;
          cnt_d   = '0;
        end
      end
      PRONTA: begin
        if (limpar) begin
          state_d = LIMPA;
          cnt_d   = '0;
          w_flush = 1'b1;
        end else begin
          w_wr_en = EscMen;
          w_rd_en = LerMen;
        end
      end
      default: begin
        state_d = LIMPA;
        cnt_d   = '0;
      end
    endcase
  end

  // Array has no reset: it is zeroed only by the sweep
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state_q == LIMPA) begin
        ram[cnt_q] <= '0;
      end else if (w_wr_en) begin
        ram[write_addr] <= data;
      end
    end
  end

  assign w_rd_word = ((MODO_COLISAO != 0) && w_wr_en && (write_addr == read_addr))
                     ? data : ram[read_addr];

  generate
    if (LATENCIA == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] pipe_data_q;
      logic                  pipe_vld_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pipe_data_q <= '0;
          pipe_vld_q  <= 1'b0;
          saida_q     <= '0;
          valida_q    <= 1'b0;
        end else begin
          pipe_vld_q <= w_rd_en;
          if (w_rd_en) begin
            pipe_data_q <= w_rd_word;
          end
          valida_q <= pipe_vld_q && !w_flush;
          if (pipe_vld_q && !w_flush) begin
            saida_q <= pipe_data_q;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          saida_q  <= '0;
          valida_q <= 1'b0;
        end else begin
          valida_q <= w_rd_en;
          if (w_rd_en) begin
            saida_q <= w_rd_word;
          end
        end
      end
    end
  endgenerate

  assign saida        = saida_q;
  assign saida_valida = valida_q;
  assign ocupada      = (state_q == LIMPA);

endmodule
`default_nettype wire

// File: tb/tb_memoria_param.sv
`default_nettype none
// ============================================================================
// tb_memoria_param : drives a read-first/latency-1 and a write-first/latency-2
//                    instance with shared stimulus against a cycle-level model.
// Revision 1.0
// ============================================================================
module tb_memoria_param;

  localparam int DEPTH = 16;
  localparam int MAXC  = 4096;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] data = '0;
  logic [3:0] write_addr = '0;
  logic [3:0] read_addr = '0;
  logic       EscMen = 1'b0;
  logic       LerMen = 1'b0;
  logic       limpar = 1'b0;
  logic [7:0] saida_a, saida_b;
  logic       vld_a, vld_b, ocup_a, ocup_b;

  memoria_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LATENCIA(1), .MODO_COLISAO(0)) u_rf (
    .clock(clock), .reset_n(reset_n), .data(data), .write_addr(write_addr),
    .read_addr(read_addr), .EscMen(EscMen), .LerMen(LerMen), .limpar(limpar),
    .saida(saida_a), .saida_valida(vld_a), .ocupada(ocup_a));

  memoria_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LATENCIA(2), .MODO_COLISAO(1)) u_wf (
    .clock(clock), .reset_n(reset_n), .data(data), .write_addr(write_addr),
    .read_addr(read_addr), .EscMen(EscMen), .LerMen(LerMen), .limpar(limpar),
    .saida(saida_b), .saida_valida(vld_b), .ocupada(ocup_b));

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         lat  [2] = '{1, 2};
  int         modo [2] = '{0, 1};
  logic [7:0] mem  [2][DEPTH];
  int         busy [2];
  logic [7:0] exp_s [2];
  logic       exp_v [2];
  bit         sched_v [2][MAXC];
  logic [7:0] sched_d [2][MAXC];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset(input int m);
    busy[m]  = DEPTH;
    exp_s[m] = '0;
    exp_v[m] = 1'b0;
    for (int i = cyc; i < cyc + 3 && i < MAXC; i++) sched_v[m][i] = 1'b0;
  endtask

  // One rising edge seen through the rules: sweep, clear request, or access
  task automatic model_step(input int m);
    logic [7:0] rd;
    if (!reset_n) begin
      model_reset(m);
      return;
    end
    exp_v[m] = 1'b0;
    if (busy[m] > 0) begin
      mem[m][DEPTH - busy[m]] = '0;
      busy[m]--;
    end else if (limpar) begin
      busy[m] = DEPTH;
      sched_v[m][cyc]     = 1'b0;
      sched_v[m][cyc + 1] = 1'b0;
    end else begin
      if (LerMen) begin
        rd = (modo[m] == 1 && EscMen && write_addr == read_addr) ? data : mem[m][read_addr];
        sched_v[m][cyc + lat[m] - 1] = 1'b1;
        sched_d[m][cyc + lat[m] - 1] = rd;
      end
      if (EscMen) mem[m][write_addr] = data;
    end
    if (sched_v[m][cyc]) begin
      exp_v[m] = 1'b1;
      exp_s[m] = sched_d[m][cyc];
      sched_v[m][cyc] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_val("rf_saida",   {24'd0, saida_a}, {24'd0, exp_s[0]});
    check_val("rf_valida",  {31'd0, vld_a},   {31'd0, exp_v[0]});
    check_val("rf_ocupada", {31'd0, ocup_a},  {31'd0, busy[0] > 0});
    check_val("wf_saida",   {24'd0, saida_b}, {24'd0, exp_s[1]});
    check_val("wf_valida",  {31'd0, vld_b},   {31'd0, exp_v[1]});
    check_val("wf_ocupada", {31'd0, ocup_b},  {31'd0, busy[1] > 0});
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit esc, input logic [3:0] wa, input logic [7:0] d,
                       input bit ler, input logic [3:0] ra, input bit lim);
    EscMen = esc; write_addr = wa; data = d;
    LerMen = ler; read_addr = ra; limpar = lim;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++) mem[m][i] = 8'hXX;

    // Asynchronous reset assertion before any clock edge
    #1 reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    idle(2);
    reset_n = 1'b1;
    idle(18);

    // Freshly swept memory reads zero
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 1'b0);
    idle(2);

    drive(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
    idle(3);

    // Same-address collision
    drive(1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b0);
    idle(1);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 1'b0);
    idle(2);

    // Back-to-back reads
    drive(1'b1, 4'd1, 8'h01, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 4'd2, 8'h02, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b0);
    idle(3);

    // Clear request swallows a simultaneous write
    drive(1'b1, 4'd9, 8'h55, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 4'd4, 8'hFF, 1'b0, 4'd0, 1'b1);
    idle(17);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd9, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd4, 1'b0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] wa, ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      drive(bit'($urandom_range(0, 1)), wa, 8'($urandom),
            bit'($urandom_range(0, 9) < 6), ra, bit'($urandom_range(0, 79) == 0));
    end
    idle(18);

    // Reset mid-sweep with a non-zero word held on saida
    drive(1'b1, 4'd2, 8'h77, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b0);
    idle(2);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b1);
    idle(8);
    #2 reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    idle(2);
    reset_n = 1'b1;
    idle(18);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd15, 1'b0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
